// File: rtl/checksum_stream_checker.sv
// Receive-side ones'-complement word checksum verifier: accumulates an
// end-around-carry sum over a valid/ready frame and holds a verdict until taken.
module checksum_stream_checker #(
   parameter int N     = 5,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_checksum,
   output logic             res_ok,
   output logic             res_len_err
);

   localparam int CW = $clog2(N + 2);

   localparam logic [1:0] ACCUM  = 2'd0;
   localparam logic [1:0] DRAIN  = 2'd1;
   localparam logic [1:0] REPORT = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] acc_next;
   logic             accept;
   logic             cnt_full;

   assign accept   = s_valid && s_ready;
   assign cnt_full = (cnt == CW'(N));

   // One end-around fold suffices: the folded result never exceeds 2^WIDTH-1.
   always_comb begin
      sum      = {1'b0, acc} + {1'b0, s_data};
      acc_next = sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum[WIDTH]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ACCUM;
         acc          <= '0;
         cnt          <= '0;
         s_ready      <= 1'b0;
         res_valid    <= 1'b0;
         res_checksum <= '0;
         res_ok       <= 1'b0;
         res_len_err  <= 1'b0;
      end else begin
         // s_ready is registered; every transition into REPORT pulls it low.
         s_ready <= 1'b1;
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc_next;
                  cnt <= cnt + CW'(1);
                  if (s_last) begin
                     state        <= REPORT;
                     s_ready      <= 1'b0;
                     res_valid    <= 1'b1;
                     res_checksum <= ~acc_next;
                     res_len_err  <= !cnt_full;
                     res_ok       <= (~acc_next == '0) && cnt_full;
                  end else if (cnt_full) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (accept && s_last) begin
                  state        <= REPORT;
                  s_ready      <= 1'b0;
                  res_valid    <= 1'b1;
                  res_checksum <= ~acc;
                  res_len_err  <= 1'b1;
                  res_ok       <= 1'b0;
               end
            end
            REPORT: begin
               s_ready <= 1'b0;
               if (res_ready) begin
                  res_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= ACCUM;
                  s_ready   <= 1'b1;
               end
            end
            default: begin
               state <= ACCUM;
            end
         endcase
      end
   end

endmodule
